// File: rtl/matrix_axil_pkg.sv
// Shared types and constants for the matrix AXI4-Lite arbiter: FSM states,
// AXI response codes and the matrix register map.
package matrix_axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_RESP,
    DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] REG_OFFSET_0 = 4'h0;
  localparam logic [3:0] REG_OFFSET_1 = 4'h4;
  localparam logic [3:0] REG_OFFSET_2 = 4'h8;
  localparam logic [3:0] REG_OFFSET_3 = 4'hC;

endpackage

// File: rtl/matrix_rr_grant2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester the pointer currently favours.
module matrix_rr_grant2
  import matrix_axil_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant_idx = 1'b0;
    case (req)
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ptr;
      default: grant_idx = 1'b0;
    endcase
    grant = (req == 2'b00) ? 2'b00 : (grant_idx ? 2'b10 : 2'b01);
  end

endmodule

// File: rtl/matrix_axil_arbiter.sv
// Two-requester arbiter in front of the matrix IP AXI4-Lite slave, one
// transaction at a time. Define MATRIX_ARB_TIMEOUT_EN to add a response watchdog.
module matrix_axil_arbiter
  import matrix_axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  state_t                  state_q, state_d;
  logic                    ptr_q, ptr_d;
  logic                    owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic [1:0]              rsp_valid_q, rsp_valid_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                    arvalid_q, arvalid_d, rready_q, rready_d;
  logic [1:0]              grant;
  logic                    grant_idx;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    timeout;

  matrix_rr_grant2 u_grant (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign sel_addr  = grant_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign sel_wdata = grant_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

`ifdef MATRIX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q;
  logic          busy;

  assign busy = (state_q == WR_ADDR) || (state_q == WR_RESP) ||
                (state_q == RD_ADDR) || (state_q == RD_RESP);

  always_ff @(posedge ACLK) begin
    if (ARESET || !busy) timer_q <= '0;
    else                 timer_q <= timer_q + TW'(1);
  end

  assign timeout = busy && (timer_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Next-state and next-output logic; every AXI-facing signal is taken from a register.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    rsp_valid_d = 2'b00;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          owner_d = grant_idx;
          addr_d  = {sel_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d = sel_wdata;
          if (req_we[grant_idx]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        // AW and W finish independently; a channel whose valid is already low is done.
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          resp_d   = M_AXI_BRESP;
          rdata_d  = '0;
          bready_d = 1'b0;
          state_d  = DONE;
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (M_AXI_RVALID) begin
          rdata_d  = M_AXI_RDATA;
          resp_d   = M_AXI_RRESP;
          rready_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        ptr_d       = ~owner_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      resp_d    = RESP_SLVERR;
      rdata_d   = '0;
      state_d   = DONE;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
      rsp_valid_q <= 2'b00;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      rsp_valid_q <= rsp_valid_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
    end
  end

  assign req_ready     = (state_q == IDLE && !ARESET) ? grant : 2'b00;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_matrix_axil_arbiter.sv
// Bench for matrix_axil_arbiter: table of single transactions against a small
// AXI4-Lite register-file slave, plus skew, contention, reset and watchdog sequences.
module tb_matrix_axil_arbiter;
  import matrix_axil_pkg::*;

  localparam int TO_CYCLES = 16;

  logic        ACLK, ARESET;
  logic [1:0]  req_valid, req_we, req_ready, rsp_valid, rsp_resp;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata;
  logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

  matrix_axil_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Slave model: register file with a tunable W delay and stall switches for B and R.
  int          w_delay;
  bit          b_never, r_hold;
  int          wcnt;
  logic [31:0] mem [4];
  logic        aw_got, w_got, r_pend;
  logic [3:0]  aw_a, r_a, aw_sel, ar_sel;
  logic [31:0] w_d, w_sel;
  logic        aw_hs, w_hs, ar_hs;

  assign M_AXI_AWREADY = 1'b1;
  assign M_AXI_ARREADY = 1'b1;
  assign M_AXI_WREADY  = (wcnt >= w_delay);
  assign M_AXI_BRESP   = RESP_OKAY;
  assign M_AXI_RRESP   = RESP_OKAY;
  assign aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs   = M_AXI_WVALID && M_AXI_WREADY;
  assign ar_hs  = M_AXI_ARVALID && M_AXI_ARREADY;
  assign aw_sel = aw_hs ? M_AXI_AWADDR : aw_a;
  assign w_sel  = w_hs ? M_AXI_WDATA : w_d;
  assign ar_sel = ar_hs ? M_AXI_ARADDR : r_a;

  always @(posedge ACLK) begin
    if (ARESET) begin
      wcnt <= 0; aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      aw_a <= '0; r_a <= '0; w_d <= '0;
      M_AXI_BVALID <= 1'b0; M_AXI_RVALID <= 1'b0; M_AXI_RDATA <= '0;
      for (int k = 0; k < 4; k++) mem[k] <= '0;
    end else begin
      if (M_AXI_WVALID && !M_AXI_WREADY) wcnt <= wcnt + 1;
      else                               wcnt <= 0;
      if (aw_hs) begin aw_got <= 1'b1; aw_a <= M_AXI_AWADDR; end
      if (w_hs)  begin w_got <= 1'b1;  w_d <= M_AXI_WDATA;   end
      if ((aw_got || aw_hs) && (w_got || w_hs) && !M_AXI_BVALID && !b_never) begin
        M_AXI_BVALID    <= 1'b1;
        mem[aw_sel[3:2]] <= w_sel;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
      if (ar_hs) begin r_pend <= 1'b1; r_a <= M_AXI_ARADDR; end
      if ((r_pend || ar_hs) && !M_AXI_RVALID && !r_hold) begin
        M_AXI_RVALID <= 1'b1;
        M_AXI_RDATA  <= mem[ar_sel[3:2]];
        r_pend <= 1'b0;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
    end
  end

  // Bus monitor: handshake counts, last observed payloads, early-BREADY detector.
  int          aw_cnt = 0, w_cnt = 0, early_cnt = 0, rsp_cnt = 0;
  logic [3:0]  last_awaddr = '0, last_araddr = '0, last_wstrb = '0;
  logic [31:0] last_wdata = '0;
  logic        mon_aw = 1'b0, mon_w = 1'b0;

  always @(posedge ACLK) begin
    if (aw_hs) begin aw_cnt <= aw_cnt + 1; last_awaddr <= M_AXI_AWADDR; end
    if (w_hs)  begin w_cnt <= w_cnt + 1; last_wdata <= M_AXI_WDATA; last_wstrb <= M_AXI_WSTRB; end
    if (ar_hs) last_araddr <= M_AXI_ARADDR;
    if (|rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (M_AXI_BREADY && !(mon_aw && mon_w)) early_cnt <= early_cnt + 1;
    if (ARESET || (M_AXI_BREADY && M_AXI_BVALID)) begin
      mon_aw <= 1'b0; mon_w <= 1'b0;
    end else begin
      if (aw_hs) mon_aw <= 1'b1;
      if (w_hs)  mon_w  <= 1'b1;
    end
  end

  int checks = 0, passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic waitReady(input int who);
    int n = 0;
    #1;
    while (!req_ready[who] && n < 100) begin
      @(negedge ACLK); #1; n++;
    end
  endtask

  task automatic driveReq(input int who, input bit we, input logic [3:0] addr, input logic [31:0] wdata);
    req_valid[who] = 1'b1;
    req_we[who]    = we;
    if (who == 1) begin req_addr[7:4] = addr; req_wdata[63:32] = wdata; end
    else          begin req_addr[3:0] = addr; req_wdata[31:0]  = wdata; end
  endtask

  task automatic applyStimulus(input int who, input bit we, input logic [3:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic [1:0] resp, output int lat);
    @(negedge ACLK);
    driveReq(who, we, addr, wdata);
    waitReady(who);
    checkOutput($sformatf("accept_req%0d", who), 32'(req_ready[who]), 32'd1);
    @(posedge ACLK); #1;
    req_valid[who] = 1'b0;
    lat = 0;
    while (!rsp_valid[who] && lat < 100) begin
      @(negedge ACLK); lat++;
    end
    rdata = rsp_rdata;
    resp  = rsp_resp;
  endtask

  typedef struct {
    int          who;
    bit          we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] rd;
  logic [1:0]  rs;
  int          lat;
  logic [3:0]  al;
  int          snap_aw, snap_w, snap_early, snap_rsp;

  initial begin
    vecs[0] = '{0, 1'b1, REG_OFFSET_0, 32'h1, 32'h0};
    vecs[1] = '{1, 1'b1, REG_OFFSET_1, 32'h2, 32'h0};
    vecs[2] = '{1, 1'b1, REG_OFFSET_2, 32'h3, 32'h0};
    vecs[3] = '{1, 1'b1, REG_OFFSET_3, 32'h4, 32'h0};
    vecs[4] = '{1, 1'b0, REG_OFFSET_1, 32'h0, 32'h2};
    vecs[5] = '{1, 1'b0, REG_OFFSET_2, 32'h0, 32'h3};
    vecs[6] = '{1, 1'b0, REG_OFFSET_3, 32'h0, 32'h4};
    vecs[7] = '{0, 1'b0, REG_OFFSET_0, 32'h0, 32'h1};
    vecs[8] = '{0, 1'b0, 4'h7,         32'h0, 32'h2};

    w_delay = 0; b_never = 1'b0; r_hold = 1'b0;
    req_valid = 2'b11; req_we = 2'b00; req_addr = '0; req_wdata = '0;
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_axi_ctrl", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 32'd0);
    checkOutput("reset_rsp", 32'({rsp_valid, rsp_resp}), 32'd0);
    req_valid = 2'b00;
    ARESET = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, rs, lat);
      al = vecs[i].addr;
      al[1:0] = 2'b00;
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      checkOutput($sformatf("v%0d_resp", i), 32'(rs), 32'(RESP_OKAY));
      if (vecs[i].we) begin
        checkOutput($sformatf("v%0d_awaddr", i), 32'(last_awaddr), 32'(al));
        checkOutput($sformatf("v%0d_wdata", i), last_wdata, vecs[i].wdata);
        checkOutput($sformatf("v%0d_wstrb", i), 32'(last_wstrb), 32'hF);
      end else begin
        checkOutput($sformatf("v%0d_araddr", i), 32'(last_araddr), 32'(al));
        checkOutput($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      end
    end

    // W channel lags AW by three cycles.
    w_delay = 3;
    snap_aw = aw_cnt; snap_w = w_cnt; snap_early = early_cnt;
    applyStimulus(0, 1'b1, REG_OFFSET_2, 32'h55, rd, rs, lat);
    checkOutput("skew_latency", 32'(lat), 32'd7);
    checkOutput("skew_aw_count", 32'(aw_cnt - snap_aw), 32'd1);
    checkOutput("skew_w_count", 32'(w_cnt - snap_w), 32'd1);
    checkOutput("skew_early_bready", 32'(early_cnt - snap_early), 32'd0);
    w_delay = 0;

    // Both requesters hold valid: grants must alternate starting at 0.
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    driveReq(0, 1'b0, REG_OFFSET_0, 32'h0);
    driveReq(1, 1'b0, REG_OFFSET_1, 32'h0);
    for (int g = 0; g < 8; g++) begin
      int n = 0;
      #1;
      while (req_ready == 2'b00 && n < 100) begin
        @(negedge ACLK); #1; n++;
      end
      checkOutput($sformatf("rr_grant%0d", g), 32'(req_ready), (g % 2 == 0) ? 32'd1 : 32'd2);
      if (g < 7) @(negedge ACLK);
    end
    @(posedge ACLK); #1;
    req_valid = 2'b00;
    repeat (6) @(negedge ACLK);

    // Reset while the read waits in RD_RESP.
    r_hold = 1'b1;
    snap_rsp = rsp_cnt;
    driveReq(1, 1'b0, REG_OFFSET_2, 32'hDEAD);
    waitReady(1);
    @(posedge ACLK); #1;
    req_valid[1] = 1'b0;
    repeat (2) @(negedge ACLK);
    checkOutput("midrst_rready_before", 32'(M_AXI_RREADY), 32'd1);
    ARESET = 1'b1;
    @(negedge ACLK);
    checkOutput("midrst_ctrl", 32'({rsp_valid, req_ready, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 32'd0);
    checkOutput("midrst_araddr", 32'(M_AXI_ARADDR), 32'd0);
    checkOutput("midrst_wdata", M_AXI_WDATA, 32'd0);
    checkOutput("midrst_rsp_data", rsp_rdata | 32'(rsp_resp), 32'd0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    r_hold = 1'b0;
    repeat (2) @(negedge ACLK);
    checkOutput("midrst_no_rsp", 32'(rsp_cnt - snap_rsp), 32'd0);
    driveReq(0, 1'b0, REG_OFFSET_0, 32'h0);
    driveReq(1, 1'b0, REG_OFFSET_1, 32'h0);
    waitReady(0);
    checkOutput("midrst_first_grant", 32'(req_ready), 32'd1);
    @(posedge ACLK); #1;
    req_valid[0] = 1'b0;
    waitReady(1);
    @(posedge ACLK); #1;
    req_valid[1] = 1'b0;
    repeat (6) @(negedge ACLK);

`ifdef MATRIX_ARB_TIMEOUT_EN
    b_never = 1'b1;
    applyStimulus(0, 1'b1, REG_OFFSET_3, 32'h9, rd, rs, lat);
    checkOutput("timeout_resp", 32'(rs), 32'(RESP_SLVERR));
    checkOutput("timeout_rdata", rd, 32'd0);
    checkOutput("timeout_latency", 32'(lat), 32'(TO_CYCLES + 2));
    b_never = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
